mem_unit: RTL and testbench

Parametrised memory-access stage for the core. It executes RV32I loads and stores (lb/lh/lw/lbu/lhu/sb/sh/sw) of any size against word-organised block RAM, or against the AXI4-Lite MMIO window (UART) on any byte lane. RAM read latency is configurable. It uses a valid/ready request port and a one-cycle response pulse, so the pipeline sequencer can issue back-to-back accesses.

---
 rtl/mem_unit_if.sv | 40 ++++
 rtl/mem_unit.sv | 380 ++++++++++++++++++++++++++++++++++++++
 tb/tb_mem_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_unit_if.sv
// -----------------------------------------------------------------------------
// mem_unit_if
//   Request/response channel between the pipeline sequencer and mem_unit.
//
//   Request  (sequencer -> mem_unit):
//     req_valid  request strobe
//     req_we     1 = store, 0 = load
//     req_op     RV32 funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu)
//     req_addr   byte address
//     req_wdata  store data, right-aligned
//   Request  (mem_unit -> sequencer):
//     req_ready  high while the unit can accept a request
//   Response (mem_unit -> sequencer):
//     resp_valid one-cycle completion pulse, no backpressure
//     resp_data  extended load data, 0 for stores and errors
//     resp_err   illegal op, misaligned access (trap build) or AXI error
//
//   Modports: master = sequencer side, slave = mem_unit side.
// -----------------------------------------------------------------------------
interface mem_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_op, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_op, req_addr, req_wdata,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// File: rtl/mem_unit.sv
// -----------------------------------------------------------------------------
// mem_unit
//   Memory-access stage executing RV32I loads/stores (lb/lh/lw/lbu/lhu/sb/sh/sw)
//   against word-organised block RAM or, when req_addr[31:24] == MMIO_TOP,
//   against an AXI4-Lite MMIO window (UART).
//
//   Parameters:
//     RAM_ADDR_W  word-address width of the RAM port
//     RAM_LAT     cycles from the ram_en cycle to valid ram_dout (1..4)
//     MMIO_TOP    req_addr[31:24] value selecting the AXI window
//     AXI_ADDR_W  AXI address width
//
//   Ports:
//     clk, rstn            clock (rising edge), asynchronous active-low reset
//     req                  mem_unit_if.slave request/response channel
//     ram_addr/din/we/en   RAM port (ram_we = byte enables, 0 for reads)
//     ram_dout             RAM read data, RAM_LAT cycles after ram_en
//     uart_axi_*           AXI4-Lite master (AR, R, AW, W, B channels)
//
//   Build option:
//     MEM_UNIT_MISALIGN_TRAP_EN  when defined, misaligned h/w accesses end in
//                                an error response with no bus activity; when
//                                undefined the low address bits are masked to
//                                natural alignment and the access proceeds.
//
//   All outputs are registered. Asserting rstn drops every valid/enable
//   immediately and abandons the access without a response.
// -----------------------------------------------------------------------------
module mem_unit #(
  parameter int         RAM_ADDR_W = 19,
  parameter int         RAM_LAT    = 1,
  parameter logic [7:0] MMIO_TOP   = 8'h7F,
  parameter int         AXI_ADDR_W = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  mem_unit_if.slave             req,
  // RAM port
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [31:0]           ram_din,
  output logic [3:0]            ram_we,
  output logic                  ram_en,
  input  logic [31:0]           ram_dout,
  // AXI4-Lite read address / data
  output logic [AXI_ADDR_W-1:0] uart_axi_araddr,
  output logic                  uart_axi_arvalid,
  input  logic                  uart_axi_arready,
  input  logic [31:0]           uart_axi_rdata,
  input  logic [1:0]            uart_axi_rresp,
  input  logic                  uart_axi_rvalid,
  output logic                  uart_axi_rready,
  // AXI4-Lite write address / data / response
  output logic [AXI_ADDR_W-1:0] uart_axi_awaddr,
  output logic                  uart_axi_awvalid,
  input  logic                  uart_axi_awready,
  output logic [31:0]           uart_axi_wdata,
  output logic [3:0]            uart_axi_wstrb,
  output logic                  uart_axi_wvalid,
  input  logic                  uart_axi_wready,
  input  logic [1:0]            uart_axi_bresp,
  input  logic                  uart_axi_bvalid,
  output logic                  uart_axi_bready
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RAM_RD = 3'd1;
  localparam logic [2:0] RAM_WR = 3'd2;
  localparam logic [2:0] AXI_RD = 3'd3;
  localparam logic [2:0] AXI_WR = 3'd4;
  localparam logic [2:0] ERR    = 3'd5;

  localparam logic [2:0] LAT_INIT = 3'(RAM_LAT);

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------

  // Byte enables for an access of the given size starting at the given lane.
  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      2'b00:   byte_en = 4'b0001 << lane;
      2'b01:   byte_en = 4'b0011 << lane;
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  // Store data replicated across the word so every lane carries the operand.
  function automatic logic [31:0] store_rep(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   store_rep = {4{d[7:0]}};
      2'b01:   store_rep = {2{d[15:0]}};
      default: store_rep = d;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then sign/zero extend by op.
  function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] lane,
                                               input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (op)
      3'b000:  load_extract = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_extract = {{16{sh[15]}}, sh[15:0]};
      3'b010:  load_extract = sh;
      3'b100:  load_extract = {24'h000000, sh[7:0]};
      3'b101:  load_extract = {16'h0000, sh[15:0]};
      default: load_extract = 32'h00000000;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [2:0]            state_r;
  logic [2:0]            op_r;
  logic [1:0]            lane_r;
  logic [2:0]            cnt_r;
  logic                  req_ready_r;
  logic                  resp_valid_r;
  logic [31:0]           resp_data_r;
  logic                  resp_err_r;
  logic [RAM_ADDR_W-1:0] ram_addr_r;
  logic [31:0]           ram_din_r;
  logic [3:0]            ram_we_r;
  logic                  ram_en_r;
  logic [AXI_ADDR_W-1:0] araddr_r;
  logic                  arvalid_r;
  logic                  rready_r;
  logic [AXI_ADDR_W-1:0] awaddr_r;
  logic                  awvalid_r;
  logic [31:0]           wdata_r;
  logic [3:0]            wstrb_r;
  logic                  wvalid_r;
  logic                  bready_r;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  logic [1:0]            size_s;
  logic [1:0]            lane_s;
  logic                  legal_s;
  logic                  misalign_s;
  logic                  is_mmio_s;
  logic                  accept_s;
  logic [31:0]           byte_addr_s;
  logic [3:0]            be_s;
  logic [31:0]           wdata_rep_s;
  logic [RAM_ADDR_W-1:0] ram_addr_s;
  logic [AXI_ADDR_W-1:0] axi_addr_s;
  logic                  aw_done_s;
  logic                  w_done_s;
  logic                  unused_s;

  // Op legality and lane selection; lane is forced to natural alignment.
  always_comb begin
    size_s  = req.req_op[1:0];
    legal_s = 1'b0;
    lane_s  = 2'b00;
    if (req.req_we) begin
      case (req.req_op)
        3'b000, 3'b001, 3'b010: legal_s = 1'b1;
        default:                legal_s = 1'b0;
      endcase
    end else begin
      case (req.req_op)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal_s = 1'b1;
        default:                                legal_s = 1'b0;
      endcase
    end
    case (size_s)
      2'b00:   lane_s = req.req_addr[1:0];
      2'b01:   lane_s = {req.req_addr[1], 1'b0};
      default: lane_s = 2'b00;
    endcase
  end

`ifdef MEM_UNIT_MISALIGN_TRAP_EN
  assign misalign_s = ((size_s == 2'b01) && req.req_addr[0]) ||
                      ((size_s == 2'b10) && (req.req_addr[1:0] != 2'b00));
`else
  assign misalign_s = 1'b0;
`endif

  assign is_mmio_s   = (req.req_addr[31:24] == MMIO_TOP);
  assign accept_s    = req.req_valid && req_ready_r;
  assign byte_addr_s = {req.req_addr[31:2], lane_s};
  assign be_s        = byte_en(size_s, lane_s);
  assign wdata_rep_s = store_rep(size_s, req.req_wdata);
  assign ram_addr_s  = req.req_addr[RAM_ADDR_W+1:2];
  assign axi_addr_s  = byte_addr_s[AXI_ADDR_W-1:0];

  // A write channel counts as done once it is low or handshaking this cycle.
  assign aw_done_s = !awvalid_r || uart_axi_awready;
  assign w_done_s  = !wvalid_r  || uart_axi_wready;

  // Address bits outside the RAM/AXI windows are deliberately ignored.
  assign unused_s = ^{byte_addr_s, req.req_addr};

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------

  // Accept, bus control and one-cycle response generation.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r      <= IDLE;
      op_r         <= 3'b000;
      lane_r       <= 2'b00;
      cnt_r        <= 3'd0;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_data_r  <= 32'h00000000;
      resp_err_r   <= 1'b0;
      ram_addr_r   <= '0;
      ram_din_r    <= 32'h00000000;
      ram_we_r     <= 4'h0;
      ram_en_r     <= 1'b0;
      araddr_r     <= '0;
      arvalid_r    <= 1'b0;
      rready_r     <= 1'b0;
      awaddr_r     <= '0;
      awvalid_r    <= 1'b0;
      wdata_r      <= 32'h00000000;
      wstrb_r      <= 4'h0;
      wvalid_r     <= 1'b0;
      bready_r     <= 1'b0;
    end else begin
      // Pulse-type outputs default low every cycle.
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_data_r  <= 32'h00000000;
      ram_en_r     <= 1'b0;
      ram_we_r     <= 4'h0;
      case (state_r)
        // ERR only spans its response cycle, in which req_ready is already
        // high, so it accepts exactly like IDLE.
        IDLE, ERR: begin
          state_r <= IDLE;
          if (accept_s) begin
            op_r   <= req.req_op;
            lane_r <= lane_s;
            if (!legal_s || misalign_s) begin
              state_r      <= ERR;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
            end else if (is_mmio_s) begin
              req_ready_r <= 1'b0;
              if (req.req_we) begin
                state_r   <= AXI_WR;
                awaddr_r  <= axi_addr_s;
                awvalid_r <= 1'b1;
                wdata_r   <= wdata_rep_s;
                wstrb_r   <= be_s;
                wvalid_r  <= 1'b1;
              end else begin
                state_r   <= AXI_RD;
                araddr_r  <= axi_addr_s;
                arvalid_r <= 1'b1;
              end
            end else begin
              req_ready_r <= 1'b0;
              ram_en_r    <= 1'b1;
              ram_addr_r  <= ram_addr_s;
              if (req.req_we) begin
                state_r   <= RAM_WR;
                ram_we_r  <= be_s;
                ram_din_r <= wdata_rep_s;
              end else begin
                state_r <= RAM_RD;
                cnt_r   <= LAT_INIT;
              end
            end
          end else begin
            req_ready_r <= 1'b1;
          end
        end

        RAM_WR: begin
          state_r      <= IDLE;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b1;
        end

        // cnt_r reaches zero on the edge closing cycle ram_en + RAM_LAT,
        // which is the first edge at which ram_dout is valid.
        RAM_RD: begin
          if (cnt_r == 3'd0) begin
            state_r      <= IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b1;
            resp_data_r  <= load_extract(op_r, lane_r, ram_dout);
          end else begin
            cnt_r <= cnt_r - 3'd1;
          end
        end

        AXI_WR: begin
          if (awvalid_r && uart_axi_awready) begin
            awvalid_r <= 1'b0;
          end else begin
            awvalid_r <= awvalid_r;
          end
          if (wvalid_r && uart_axi_wready) begin
            wvalid_r <= 1'b0;
          end else begin
            wvalid_r <= wvalid_r;
          end
          if (!bready_r) begin
            bready_r <= aw_done_s && w_done_s;
          end else if (uart_axi_bvalid) begin
            bready_r     <= 1'b0;
            state_r      <= IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b1;
            resp_err_r   <= (uart_axi_bresp != 2'b00);
          end else begin
            bready_r <= 1'b1;
          end
        end

        AXI_RD: begin
          if (arvalid_r) begin
            if (uart_axi_arready) begin
              arvalid_r <= 1'b0;
              rready_r  <= 1'b1;
            end else begin
              arvalid_r <= 1'b1;
            end
          end else if (rready_r && uart_axi_rvalid) begin
            rready_r     <= 1'b0;
            state_r      <= IDLE;
            req_ready_r  <= 1'b1;
            resp_valid_r <= 1'b1;
            resp_err_r   <= (uart_axi_rresp != 2'b00);
            resp_data_r  <= (uart_axi_rresp == 2'b00) ?
                            load_extract(op_r, lane_r, uart_axi_rdata) : 32'h00000000;
          end else begin
            rready_r <= rready_r;
          end
        end

        // Unreachable encodings recover to a clean idle state.
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
          arvalid_r   <= 1'b0;
          rready_r    <= 1'b0;
          awvalid_r   <= 1'b0;
          wvalid_r    <= 1'b0;
          bready_r    <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign req.req_ready  = req_ready_r;
  assign req.resp_valid = resp_valid_r;
  assign req.resp_data  = resp_data_r;
  assign req.resp_err   = resp_err_r;

  assign ram_addr = ram_addr_r;
  assign ram_din  = ram_din_r;
  assign ram_we   = ram_we_r;
  assign ram_en   = ram_en_r;

  assign uart_axi_araddr  = araddr_r;
  assign uart_axi_arvalid = arvalid_r;
  assign uart_axi_rready  = rready_r;
  assign uart_axi_awaddr  = awaddr_r;
  assign uart_axi_awvalid = awvalid_r;
  assign uart_axi_wdata   = wdata_r;
  assign uart_axi_wstrb   = wstrb_r;
  assign uart_axi_wvalid  = wvalid_r;
  assign uart_axi_bready  = bready_r;

endmodule

// File: tb/tb_mem_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_unit
//   Directed scoreboard bench for mem_unit (RAM_LAT = 2). Stimulus tasks push
//   the hand-computed response (data, err, expected cycle) into a queue; a
//   monitor pops and compares on every resp_valid. A RAM model and an AXI
//   slave model with programmable ready delays stand in for the buses.
// -----------------------------------------------------------------------------
module tb_mem_unit;
  localparam int RAM_ADDR_W = 19;
  localparam int RAM_LAT    = 2;
  localparam int AXI_ADDR_W = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  mem_unit_if ifc ();

  logic [RAM_ADDR_W-1:0] ram_addr;
  logic [31:0]           ram_din;
  logic [3:0]            ram_we;
  logic                  ram_en;
  logic [31:0]           ram_dout = 32'h0;

  logic [AXI_ADDR_W-1:0] araddr;
  logic                  arvalid;
  logic                  arready = 1'b0;
  logic [31:0]           rdata   = 32'h0;
  logic [1:0]            rresp   = 2'b00;
  logic                  rvalid  = 1'b0;
  logic                  rready;
  logic [AXI_ADDR_W-1:0] awaddr;
  logic                  awvalid;
  logic                  awready = 1'b0;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic                  wvalid;
  logic                  wready  = 1'b0;
  logic [1:0]            bresp   = 2'b00;
  logic                  bvalid  = 1'b0;
  logic                  bready;

  mem_unit #(
    .RAM_ADDR_W (RAM_ADDR_W),
    .RAM_LAT    (RAM_LAT),
    .MMIO_TOP   (8'h7F),
    .AXI_ADDR_W (AXI_ADDR_W)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .req              (ifc),
    .ram_addr         (ram_addr),
    .ram_din          (ram_din),
    .ram_we           (ram_we),
    .ram_en           (ram_en),
    .ram_dout         (ram_dout),
    .uart_axi_araddr  (araddr),
    .uart_axi_arvalid (arvalid),
    .uart_axi_arready (arready),
    .uart_axi_rdata   (rdata),
    .uart_axi_rresp   (rresp),
    .uart_axi_rvalid  (rvalid),
    .uart_axi_rready  (rready),
    .uart_axi_awaddr  (awaddr),
    .uart_axi_awvalid (awvalid),
    .uart_axi_awready (awready),
    .uart_axi_wdata   (wdata),
    .uart_axi_wstrb   (wstrb),
    .uart_axi_wvalid  (wvalid),
    .uart_axi_wready  (wready),
    .uart_axi_bresp   (bresp),
    .uart_axi_bvalid  (bvalid),
    .uart_axi_bready  (bready)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- bookkeeping
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int accept_cnt = 0;
  int bus_cnt = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
    logic [31:0] cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rstn && ifc.req_valid && ifc.req_ready) accept_cnt <= accept_cnt + 1;
  end

  // ---------------------------------------------------------------- RAM model
  logic [31:0] mem [0:255];
  logic [31:0] rd1 = 32'h0;
  logic [31:0] wtmp;

  initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;

  always @(posedge clk) begin
    if (ram_en) begin
      wtmp = mem[ram_addr[7:0]];
      for (int b = 0; b < 4; b++) if (ram_we[b]) wtmp[8*b +: 8] = ram_din[8*b +: 8];
      mem[ram_addr[7:0]] <= wtmp;
      rd1 <= mem[ram_addr[7:0]];
    end
    ram_dout <= rd1;
  end

  // ---------------------------------------------------------------- AXI slave model
  int aw_dly = 1, w_dly = 1, ar_dly = 1, r_dly = 1;
  logic [1:0]  bresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;
  logic [1:0]  rresp_cfg = 2'b00;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int aw_hold = 0, w_hold = 0, b_early = 0;
  logic [31:0] aw_cap = 32'h0, wd_cap = 32'h0, ws_cap = 32'h0, ar_cap = 32'h0;

  always @(negedge clk) begin
    if (ram_en || awvalid || arvalid) bus_cnt++;
    if (awvalid) begin
      aw_cnt++;
      awready = (aw_cnt >= aw_dly);
      if (awready) begin aw_hold = aw_cnt; aw_cap = 32'(awaddr); end
    end else begin
      aw_cnt = 0; awready = 1'b0;
    end
    if (wvalid) begin
      w_cnt++;
      wready = (w_cnt >= w_dly);
      if (wready) begin w_hold = w_cnt; wd_cap = wdata; ws_cap = 32'(wstrb); end
    end else begin
      w_cnt = 0; wready = 1'b0;
    end
    if (bready && (awvalid || wvalid)) b_early++;
    bvalid = bready;
    bresp  = bready ? bresp_cfg : 2'b00;
    if (arvalid) begin
      ar_cnt++;
      arready = (ar_cnt >= ar_dly);
      if (arready) ar_cap = 32'(araddr);
    end else begin
      ar_cnt = 0; arready = 1'b0;
    end
    if (rready) begin
      r_cnt++;
      rvalid = (r_cnt >= r_dly);
    end else begin
      r_cnt = 0; rvalid = 1'b0;
    end
    rdata = rvalid ? rdata_cfg : 32'h0;
    rresp = rvalid ? rresp_cfg : 2'b00;
  end

  // ---------------------------------------------------------------- response monitor
  always @(negedge clk) begin
    if (rstn && ifc.resp_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_resp: got resp_valid with data 0x%08h, required no response (cycle %0d)",
                 ifc.resp_data, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        chk("resp_data", ifc.resp_data, mon_e.data);
        chk("resp_err", {31'h0, ifc.resp_err}, {31'h0, mon_e.err});
        chk("resp_cycle", 32'(cyc), mon_e.cyc);
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  // Drives one request at a negedge, waits for acceptance, pushes the expected
  // response (lat cycles after the accept cycle) and returns at negedge T+1.
  task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic expect_resp,
                       input logic [31:0] exp_d, input logic exp_e, input int lat,
                       output int t_acc);
    int g = 0;
    exp_t e;
    @(negedge clk);
    while (!ifc.req_ready && g < 200) begin @(negedge clk); g++; end
    if (!ifc.req_ready) chk("ready_timeout", {31'h0, ifc.req_ready}, 32'h1);
    ifc.req_valid = 1'b1;
    ifc.req_we    = we;
    ifc.req_op    = op;
    ifc.req_addr  = addr;
    ifc.req_wdata = wd;
    t_acc = cyc;
    if (expect_resp) begin
      e.data = exp_d; e.err = exp_e; e.cyc = 32'(cyc + lat);
      sb_q.push_back(e);
    end
    @(negedge clk);
    ifc.req_valid = 1'b0;
    ifc.req_addr  = 32'hxxxxxxxx;
    ifc.req_wdata = 32'hxxxxxxxx;
  endtask

  task automatic drain();
    int g = 0;
    while (sb_q.size() != 0 && g < 300) begin @(negedge clk); g++; end
    chk("drain", 32'(sb_q.size()), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int t, t1, t2, acc0, bus0;

  initial begin
    ifc.req_valid = 1'b0;
    ifc.req_we    = 1'b0;
    ifc.req_op    = 3'b000;
    ifc.req_addr  = 32'h0;
    ifc.req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'h0, ifc.req_ready}, 32'h1);
    chk("rst_resp_valid", {31'h0, ifc.resp_valid}, 32'h0);
    chk("rst_ram_en", {31'h0, ram_en}, 32'h0);
    chk("rst_valids", {28'h0, arvalid, awvalid, wvalid, 1'b0}, 32'h0);
    chk("rst_readies", {30'h0, rready, bready}, 32'h0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // sw / lw round trip
    issue(1'b1, 3'b010, 32'h00000100, 32'hDEADBEEF, 1'b1, 32'h0, 1'b0, 2, t);
    chk("sw_ram_en", {31'h0, ram_en}, 32'h1);
    chk("sw_ram_we", {28'h0, ram_we}, 32'hF);
    chk("sw_ram_addr", 32'(ram_addr), 32'h40);
    chk("sw_ram_din", ram_din, 32'hDEADBEEF);
    issue(1'b0, 3'b010, 32'h00000100, 32'h0, 1'b1, 32'hDEADBEEF, 1'b0, 2 + RAM_LAT, t);
    chk("lw_ram_en", {31'h0, ram_en}, 32'h1);
    chk("lw_ram_we", {28'h0, ram_we}, 32'h0);
    drain();

    // back-to-back stores: one accept every two cycles
    issue(1'b1, 3'b010, 32'h00000104, 32'h11223344, 1'b1, 32'h0, 1'b0, 2, t1);
    issue(1'b1, 3'b010, 32'h00000108, 32'h55667788, 1'b1, 32'h0, 1'b0, 2, t2);
    chk("b2b_gap", 32'(t2 - t1), 32'd2);
    issue(1'b0, 3'b010, 32'h00000108, 32'h0, 1'b1, 32'h55667788, 1'b0, 2 + RAM_LAT, t);
    drain();

    // byte store and sign/zero-extended sub-word loads
    issue(1'b1, 3'b000, 32'h00000103, 32'h00000080, 1'b1, 32'h0, 1'b0, 2, t);
    chk("sb_ram_we", {28'h0, ram_we}, 32'h8);
    chk("sb_ram_din", ram_din, 32'h80808080);
    issue(1'b0, 3'b000, 32'h00000103, 32'h0, 1'b1, 32'hFFFFFF80, 1'b0, 2 + RAM_LAT, t);
    issue(1'b0, 3'b100, 32'h00000103, 32'h0, 1'b1, 32'h00000080, 1'b0, 2 + RAM_LAT, t);
    issue(1'b0, 3'b001, 32'h00000102, 32'h0, 1'b1, 32'hFFFF80AD, 1'b0, 2 + RAM_LAT, t);
    issue(1'b0, 3'b101, 32'h00000102, 32'h0, 1'b1, 32'h000080AD, 1'b0, 2 + RAM_LAT, t);
    drain();

    // AXI halfword store: awready after 3 cycles, wready at once, SLVERR
    aw_dly = 3; w_dly = 1; bresp_cfg = 2'b10;
    issue(1'b1, 3'b001, 32'h7F000004, 32'h00001234, 1'b1, 32'h0, 1'b1, 5, t);
    drain();
    chk("axw_aw_hold", 32'(aw_hold), 32'd3);
    chk("axw_w_hold", 32'(w_hold), 32'd1);
    chk("axw_wstrb", ws_cap, 32'h3);
    chk("axw_wdata", wd_cap, 32'h12341234);
    chk("axw_awaddr", aw_cap, 32'h4);
    chk("axw_bready_early", 32'(b_early), 32'h0);
    aw_dly = 1; bresp_cfg = 2'b00;

    // AXI byte load
    ar_dly = 1; r_dly = 1; rdata_cfg = 32'h00000041; rresp_cfg = 2'b00;
    issue(1'b0, 3'b100, 32'h7F000000, 32'h0, 1'b1, 32'h00000041, 1'b0, 3, t);
    drain();
    chk("axr_araddr", ar_cap, 32'h0);

    // reset in the middle of an AXI read: everything drops, no response
    r_dly = 1000;
    issue(1'b0, 3'b010, 32'h7F000008, 32'h0, 1'b0, 32'h0, 1'b0, 0, t);
    @(negedge clk);
    chk("rst_mid_rready_pre", {31'h0, rready}, 32'h1);
    #2 rstn = 1'b0;
    #1;
    chk("rst_mid_rready", {31'h0, rready}, 32'h0);
    chk("rst_mid_arvalid", {31'h0, arvalid}, 32'h0);
    chk("rst_mid_req_ready", {31'h0, ifc.req_ready}, 32'h1);
    @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    r_dly = 1;

    // misaligned word load
    bus0 = bus_cnt;
`ifdef MEM_UNIT_MISALIGN_TRAP_EN
    issue(1'b0, 3'b010, 32'h00000102, 32'h0, 1'b1, 32'h0, 1'b1, 1, t);
    drain();
    chk("mis_no_bus", 32'(bus_cnt - bus0), 32'h0);
`else
    issue(1'b0, 3'b010, 32'h00000102, 32'h0, 1'b1, 32'h80ADBEEF, 1'b0, 2 + RAM_LAT, t);
    chk("mis_ram_addr", 32'(ram_addr), 32'h40);
    drain();
`endif

    // illegal ops: error at T+1, no bus activity
    bus0 = bus_cnt;
    issue(1'b0, 3'b111, 32'h00000100, 32'h0, 1'b1, 32'h0, 1'b1, 1, t);
    issue(1'b1, 3'b011, 32'h7F000000, 32'h0, 1'b1, 32'h0, 1'b1, 1, t);
    drain();
    chk("illegal_no_bus", 32'(bus_cnt - bus0), 32'h0);

    // request held high across a busy load: exactly one accept
    acc0 = accept_cnt;
    @(negedge clk);
    ifc.req_valid = 1'b1;
    ifc.req_we    = 1'b0;
    ifc.req_op    = 3'b010;
    ifc.req_addr  = 32'h00000104;
    mon_e.data = 32'h11223344; mon_e.err = 1'b0; mon_e.cyc = 32'(cyc + 2 + RAM_LAT);
    sb_q.push_back(mon_e);
    repeat (3) @(negedge clk);
    ifc.req_valid = 1'b0;
    drain();
    chk("held_one_accept", 32'(accept_cnt - acc0), 32'd1);

    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
